// File: rtl/text_console_writer_if.sv
// rtl/text_console_writer_if.sv - byte stream in, character RAM write port and cursor/status out
interface text_console_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear_req;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [6:0]  ram_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  modport master (
    output in_valid, in_data, clear_req,
    input  in_ready, ram_addr, ram_we, ram_data, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_data, clear_req,
    output in_ready, ram_addr, ram_we, ram_data, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - ASCII byte stream to 80x60 character RAM writer with cursor and full clear
// Optional: CONSOLE_CLEAR_ON_RESET_EN makes reset start a full-screen clear.
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input logic clk,
  input logic rst,
  text_console_writer_if.slave bus
);
  localparam logic [0:0]  IDLE      = 1'b0;
  localparam logic [0:0]  CLEAR     = 1'b1;
  localparam logic [6:0]  SPACE     = 7'h20;
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [12:0] ROW_PITCH = 13'(COLS);
  localparam logic [12:0] CELLS     = 13'(COLS * ROWS);

  logic [0:0]  state;
  logic [6:0]  col;
  logic [5:0]  row;
  logic [12:0] lin;      // always row*COLS + col, kept incrementally
  logic [12:0] clrAddr;  // next address the clear sequence writes
  logic        ramWe;
  logic [12:0] ramAddr;
  logic [6:0]  ramData;

  logic        inReady;
  logic        accept;
  logic        startClr;
  logic [12:0] rowBase;

  assign inReady  = (state == IDLE) && !bus.clear_req;
  assign accept   = bus.in_valid && inReady;
  assign startClr = (state == IDLE) && (bus.clear_req || (accept && bus.in_data == 8'h0C));
  assign rowBase  = lin - {6'd0, col};

  always_ff @(posedge clk) begin
    if (rst) begin
      ramWe   <= 1'b0;
      ramAddr <= '0;
      ramData <= SPACE;
      col     <= '0;
      row     <= '0;
      lin     <= '0;
      clrAddr <= '0;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
      state   <= CLEAR;
`else
      state   <= IDLE;
`endif
    end else begin
      ramWe <= 1'b0;
      case (state)
        CLEAR: begin
          if (clrAddr == CELLS) begin
            state <= IDLE;
          end else begin
            ramWe   <= 1'b1;
            ramAddr <= clrAddr;
            ramData <= SPACE;
            clrAddr <= clrAddr + 13'd1;
          end
        end
        default: begin
          if (startClr) begin
            // Address 0 goes out on the edge that starts the clear.
            state   <= CLEAR;
            ramWe   <= 1'b1;
            ramAddr <= '0;
            ramData <= SPACE;
            clrAddr <= 13'd1;
            col     <= '0;
            row     <= '0;
            lin     <= '0;
          end else if (accept) begin
            if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
              ramWe   <= 1'b1;
              ramAddr <= lin;
              ramData <= bus.in_data[6:0];
              if (col == LAST_COL) begin
                col <= '0;
                if (row == LAST_ROW) begin
                  row <= '0;
                  lin <= '0;
                end else begin
                  row <= row + 6'd1;
                  lin <= lin + 13'd1;
                end
              end else begin
                col <= col + 7'd1;
                lin <= lin + 13'd1;
              end
            end else if (bus.in_data == 8'h0A) begin
              col <= '0;
              if (row == LAST_ROW) begin
                row <= '0;
                lin <= '0;
              end else begin
                row <= row + 6'd1;
                lin <= rowBase + ROW_PITCH;
              end
            end else if (bus.in_data == 8'h0D) begin
              col <= '0;
              lin <= rowBase;
            end else if (bus.in_data == 8'h08) begin
              // Stepping back from col 0 lands on the previous row's last cell, still lin-1.
              if (col != 7'd0 || row != 6'd0) begin
                ramWe   <= 1'b1;
                ramAddr <= lin - 13'd1;
                ramData <= SPACE;
                lin     <= lin - 13'd1;
                if (col != 7'd0) begin
                  col <= col - 7'd1;
                end else begin
                  col <= LAST_COL;
                  row <= row - 6'd1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.ram_we     = ramWe;
  assign bus.ram_addr   = ramAddr;
  assign bus.ram_data   = ramData;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;
  assign bus.busy       = (state == CLEAR);
endmodule
